uart_line_echo: RTL and testbench
=================================

UART_LINE_ECHO -- requirements
Module: uart_line_echo

Interface
REQ-001 SHALL have parameter DEPTH, default 32, line buffer capacity in bytes (power of two, 4..256).
REQ-002 SHALL have parameter TERMINATOR, default 8'h0D, end-of-line byte.
REQ-003 SHALL have parameter BACKSPACE, default 8'h08, erase-last-byte code.
REQ-004 SHALL have port clk, input, 1, system clock; the block uses one clock only.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port i_rx_data, input, 8, received byte from the UART receiver.
REQ-007 SHALL have port i_rx_data_valid, input, 1, single-cycle strobe qualifying i_rx_data.
REQ-008 SHALL have port o_tx_data, output, 8, byte offered to the UART transmitter.
REQ-009 SHALL have port o_tx_data_valid, output, 1, o_tx_data is valid.
REQ-010 SHALL have port i_tx_ready, input, 1, transmitter accepts a byte this cycle.
REQ-011 SHALL have port o_busy, output, 1, high while not in COLLECT.
REQ-012 SHALL have port o_line_len, output, $clog2(DEPTH+1), bytes currently stored.
REQ-013 SHALL have port o_overrun, output, 1, single-cycle pulse when a received byte is dropped.

Function
REQ-014 SHALL implement states COLLECT, SEND, SEND_CR, SEND_LF; reset state COLLECT.
REQ-015 COLLECT, strobe with ordinary byte, count<DEPTH: SHALL write byte at buf[count], count+1 on the next edge.
REQ-016 COLLECT, strobe with BACKSPACE: SHALL decrement count if count>0, else ignore; the byte is never stored.
REQ-017 COLLECT, strobe with TERMINATOR: SHALL not store it, reset read index to 0, go to SEND (count>0) or SEND_CR (count==0).
REQ-018 COLLECT, storing the byte that makes count==DEPTH: SHALL go to SEND on the same edge (auto-flush, no terminator needed).
REQ-019 SEND: SHALL drive o_tx_data=buf[rd_idx], o_tx_data_valid=1 from the first SEND cycle (one cycle after the terminating strobe).
REQ-020 Transfer SHALL occur only in a cycle with o_tx_data_valid and i_tx_ready both high; o_tx_data SHALL stay stable until transferred.
REQ-021 SEND, transfer with rd_idx==count-1: SHALL go to SEND_CR; otherwise rd_idx+1.
REQ-022 SEND_CR SHALL offer 8'h0D, then SEND_LF SHALL offer 8'h0A, each held until transferred; after the LF transfer go to COLLECT with count=0.
REQ-023 Any i_rx_data_valid strobe outside COLLECT SHALL be dropped and pulse o_overrun for exactly one cycle, next cycle.
REQ-024 o_tx_data_valid SHALL be 0 in COLLECT; i_tx_ready SHALL be ignored in COLLECT.
REQ-025 o_line_len SHALL equal count at all times, including during SEND (count unchanged until return to COLLECT).
REQ-026 Maximum throughput SHALL be one transfer per cycle when i_tx_ready is held high.
REQ-027 Buffer SHALL be a synchronous-write array inferrable as EBR or LUT RAM; read path SHALL meet REQ-019 without extra latency.

Reset
REQ-028 Asserting reset SHALL immediately force state=COLLECT, count=0, rd_idx=0, o_tx_data_valid=0, o_overrun=0, o_busy=0, o_tx_data=8'h00.
REQ-029 Reset asserted mid-SEND SHALL abandon the line; no further bytes SHALL be offered after release.
REQ-030 Buffer contents SHALL not require reset.

Verification
REQ-031 Bench SHALL cover: strobes 'A','B','C',0x0D, i_tx_ready=1 -> tx sequence 0x41,0x42,0x43,0x0D,0x0A, valid first asserted the cycle after the 0x0D strobe, o_line_len=3 during send, 0 afterwards.
REQ-032 Bench SHALL cover: 'X','Y',0x08,'Z',0x0D -> tx 0x58,0x5A,0x0D,0x0A.
REQ-033 Bench SHALL cover: 0x08 then 0x0D on an empty line -> tx 0x0D,0x0A only; count stays 0.
REQ-034 Bench SHALL cover: DEPTH=4, bytes 1,2,3,4 -> auto-flush 0x01..0x04,0x0D,0x0A; a fifth strobe during send -> one o_overrun pulse and the byte is absent from any later output.
REQ-035 Bench SHALL cover: i_tx_ready toggling randomly -> o_tx_data stable while valid and not ready, every byte transferred exactly once, in order.
REQ-036 Bench SHALL cover: reset pulse after the second of five transfers -> o_tx_data_valid=0 within the same cycle, o_busy=0, a new line 'Q',0x0D -> tx 0x51,0x0D,0x0A.

Source files
------------

// File: rtl/uart_line_echo.sv
// Line-buffered UART echo: collects received bytes until TERMINATOR (or a full
// buffer), then replays the line followed by CR/LF to the transmitter.
module uart_line_echo #(
    parameter int unsigned DEPTH      = 32,
    parameter logic [7:0]  TERMINATOR = 8'h0D,
    parameter logic [7:0]  BACKSPACE  = 8'h08
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_rx_data_valid,
    output logic [7:0]                   o_tx_data,
    output logic                         o_tx_data_valid,
    input  logic                         i_tx_ready,
    output logic                         o_busy,
    output logic [$clog2(DEPTH+1)-1:0]   o_line_len,
    output logic                         o_overrun
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        COLLECT,
        SEND,
        SEND_CR,
        SEND_LF
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [AW-1:0]   rd_idx, rd_idx_nxt;
    logic            wr_en;
    logic [7:0]      mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= COLLECT;
            count     <= '0;
            rd_idx    <= '0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            rd_idx    <= rd_idx_nxt;
            o_overrun <= i_rx_data_valid && (state != COLLECT);
        end
    end

    // Unreset storage with asynchronous read, so SEND can present buf[rd_idx]
    // in its first cycle without a prefetch stage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= i_rx_data;
        end
    end

    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        rd_idx_nxt      = rd_idx;
        wr_en           = 1'b0;
        o_tx_data_valid = 1'b0;
        o_tx_data       = '0;
        case (state)
            COLLECT: begin
                if (i_rx_data_valid) begin
                    if (i_rx_data == TERMINATOR) begin
                        rd_idx_nxt = '0;
                        state_nxt  = (count == '0) ? SEND_CR : SEND;
                    end else if (i_rx_data == BACKSPACE) begin
                        if (count != '0) begin
                            count_nxt = count - CW'(1);
                        end
                    end else if (count < CW'(DEPTH)) begin
                        wr_en     = 1'b1;
                        count_nxt = count + CW'(1);
                        if (count == CW'(DEPTH - 1)) begin
                            rd_idx_nxt = '0;
                            state_nxt  = SEND;
                        end
                    end
                end
            end
            SEND: begin
                o_tx_data_valid = 1'b1;
                o_tx_data       = mem[rd_idx];
                if (i_tx_ready) begin
                    if (CW'(rd_idx) == count - CW'(1)) begin
                        state_nxt = SEND_CR;
                    end else begin
                        rd_idx_nxt = rd_idx + AW'(1);
                    end
                end
            end
            SEND_CR: begin
                o_tx_data_valid = 1'b1;
                o_tx_data       = 8'h0D;
                if (i_tx_ready) begin
                    state_nxt = SEND_LF;
                end
            end
            SEND_LF: begin
                o_tx_data_valid = 1'b1;
                o_tx_data       = 8'h0A;
                if (i_tx_ready) begin
                    state_nxt  = COLLECT;
                    count_nxt  = '0;
                    rd_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    assign o_busy     = (state != COLLECT);
    assign o_line_len = count;

endmodule

// File: tb/tb_uart_line_echo.sv
// Directed bench for uart_line_echo: a DEPTH=32 instance for line handling,
// random back-pressure and reset, plus a DEPTH=4 instance for auto-flush.
module tb_uart_line_echo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data, rx4_data;
    logic       rx_valid, rx4_valid;
    logic [7:0] tx_data, tx4_data;
    logic       tx_valid, tx4_valid;
    logic       tx_ready, tx4_ready;
    logic       busy, busy4, ovr, ovr4;
    logic [5:0] len;
    logic [2:0] len4;

    int checks   = 0;
    int failures = 0;

    logic [7:0] txq[$];
    logic [7:0] txq4[$];
    logic [7:0] exp_q[$];
    int         ovr_cnt  = 0;
    int         ovr4_cnt = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always #5 clk = ~clk;

    uart_line_echo dut (
        .clk             (clk),
        .reset           (reset),
        .i_rx_data       (rx_data),
        .i_rx_data_valid (rx_valid),
        .o_tx_data       (tx_data),
        .o_tx_data_valid (tx_valid),
        .i_tx_ready      (tx_ready),
        .o_busy          (busy),
        .o_line_len      (len),
        .o_overrun       (ovr)
    );

    uart_line_echo #(.DEPTH(4)) dut4 (
        .clk             (clk),
        .reset           (reset),
        .i_rx_data       (rx4_data),
        .i_rx_data_valid (rx4_valid),
        .o_tx_data       (tx4_data),
        .o_tx_data_valid (tx4_valid),
        .i_tx_ready      (tx4_ready),
        .o_busy          (busy4),
        .o_line_len      (len4),
        .o_overrun       (ovr4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs only change at posedge+1, so a valid&&ready seen here transfers at the next edge.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (tx4_valid && tx4_ready) txq4.push_back(tx4_data);
        if (ovr) ovr_cnt++;
        if (ovr4) ovr4_cnt++;
        if (!reset && prev_valid && !prev_ready)
            check("hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
        prev_valid = reset ? 1'b0 : tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
    end

    task automatic strobe(input bit sel, input logic [7:0] b);
        if (sel) begin
            rx4_data  = b;
            rx4_valid = 1'b1;
        end else begin
            rx_data  = b;
            rx_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        rx4_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit sel);
        int n = 0;
        while ((sel ? busy4 : busy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, 32'(sel ? busy4 : busy), 32'd0);
    endtask

    task automatic check_q(input string tag, input bit sel);
        logic [7:0] got[$];
        got = sel ? txq4 : txq;
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_%0d", tag, i),
                  (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
        if (sel) txq4.delete();
        else txq.delete();
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        rx_valid = 1'b0; rx4_valid = 1'b0;
        rx_data = 8'h00; rx4_data = 8'h00;
        tx_ready = 1'b0; tx4_ready = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", tx_data, 0);
        check("rst_len", len, 0);
        check("rst_ovr", ovr, 0);
        check("rst_len4", len4, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ABC<CR>, ready held high (also ignored while collecting)
        tx_ready = 1'b1;
        strobe(0, 8'h41); strobe(0, 8'h42); strobe(0, 8'h43);
        check("t1_len", len, 3);
        check("t1_idle_valid", tx_valid, 0);
        strobe(0, 8'h0D);
        check("t1_first_valid", tx_valid, 1);
        check("t1_first_data", tx_data, 8'h41);
        check("t1_len_send", len, 3);
        check("t1_busy", busy, 1);
        wait_idle("t1", 0);
        check("t1_len_after", len, 0);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
        check_q("t1_q", 0);

        // Backspace mid-line
        strobe(0, 8'h58); strobe(0, 8'h59); strobe(0, 8'h08); strobe(0, 8'h5A);
        check("t2_len", len, 2);
        strobe(0, 8'h0D);
        wait_idle("t2", 0);
        exp_q = '{8'h58, 8'h5A, 8'h0D, 8'h0A};
        check_q("t2_q", 0);

        // Backspace and terminator on an empty line
        strobe(0, 8'h08);
        check("t3_len_bs", len, 0);
        strobe(0, 8'h0D);
        check("t3_busy", busy, 1);
        check("t3_data", tx_data, 8'h0D);
        check("t3_len_send", len, 0);
        wait_idle("t3", 0);
        check("t3_len_after", len, 0);
        exp_q = '{8'h0D, 8'h0A};
        check_q("t3_q", 0);

        // DEPTH=4 auto-flush with a strobe dropped during send
        tx4_ready = 1'b1;
        strobe(1, 8'h01); strobe(1, 8'h02); strobe(1, 8'h03);
        check("t4_len3", len4, 3);
        check("t4_busy3", busy4, 0);
        strobe(1, 8'h04);
        check("t4_busy", busy4, 1);
        check("t4_len_full", len4, 4);
        check("t4_valid", tx4_valid, 1);
        check("t4_data0", tx4_data, 8'h01);
        strobe(1, 8'h55);
        check("t4_ovr_pulse", ovr4, 1);
        @(posedge clk);
        #1;
        check("t4_ovr_clear", ovr4, 0);
        wait_idle("t4", 1);
        check("t4_ovr_cnt", ovr4_cnt, 1);
        check("t4_len_after", len4, 0);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'h0A};
        check_q("t4_q", 1);
        check("t1_ovr_cnt", ovr_cnt, 0);

        // Random back-pressure
        tx_ready = 1'b0;
        strobe(0, 8'h48); strobe(0, 8'h65); strobe(0, 8'h6C); strobe(0, 8'h6C); strobe(0, 8'h6F);
        strobe(0, 8'h0D);
        for (int i = 0; i < 300 && busy; i++) begin
            tx_ready = (i >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        check("t5_done", busy, 0);
        exp_q = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
        check_q("t5_q", 0);

        // Reset after the second of five transfers
        tx_ready = 1'b1;
        strobe(0, 8'h61); strobe(0, 8'h62); strobe(0, 8'h63);
        strobe(0, 8'h0D);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("t6_valid", tx_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_data", tx_data, 0);
        check("t6_len", len, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q = '{8'h61, 8'h62};
        check_q("t6_abandon", 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("t6_quiet_valid", tx_valid, 0);
        check("t6_quiet_q", txq.size(), 0);
        strobe(0, 8'h51);
        strobe(0, 8'h0D);
        wait_idle("t6", 0);
        exp_q = '{8'h51, 8'h0D, 8'h0A};
        check_q("t6_q", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
